// File: rtl/io_hub.sv
// -----------------------------------------------------------------------------
// io_hub -- memory-mapped IO subsystem for the single-cycle CPU.
//
// Gives the CPU one halfword-register window onto the board LEDs, switches and
// push buttons. Switches and buttons are brought into the clock domain with two
// flops each. Every button is then debounced by its own counter. A rising
// debounced level raises a sticky event flag. A rising button 0 ("submit") also
// captures a snapshot of the synchronised switches.
//
// Register map (byte address, halfword registers; odd addresses read 0):
//   0x0 LED[15:0]           R/W
//   0x2 LED[LED_W-1:16]     R/W
//   0x4 SW_sync[15:0]       R
//   0x6 SW_sync[SW_W-1:16]  R
//   0x8 btn_level           R
//   0xA event flags         R (read-clear), W1C
//   0xC snapshot[15:0]      R
//   0xE snapshot[SW_W-1:16] R
//
// Ports:
//   clock          system (CPU) clock
//   reset          synchronous, active-high reset; priority over everything
//   io_sel         address decoded to the IO hub region
//   io_read        CPU IO read strobe
//   io_write       CPU IO write strobe
//   addr[3:0]      low byte-address bits
//   wdata[15:0]    write data
//   rdata[15:0]    read data, combinational from registered state
//   switches       raw board switches
//   buttons        raw board buttons
//   leds           LED drive, registered
//   btn_level      debounced button levels
//   event_pending  OR of all event flags, registered
// -----------------------------------------------------------------------------
module io_hub #(
    parameter int LED_W        = 24,  // 1..32
    parameter int SW_W         = 24,  // 1..32
    parameter int BTN_N        = 2,   // 1..16
    parameter int DEBOUNCE_CYC = 20   // >= 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_sel,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [3:0]        addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    input  logic [SW_W-1:0]   switches,
    input  logic [BTN_N-1:0]  buttons,
    output logic [LED_W-1:0]  leds,
    output logic [BTN_N-1:0]  btn_level,
    output logic              event_pending
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [3:0] ADDR_LED_LO  = 4'h0;
    localparam logic [3:0] ADDR_LED_HI  = 4'h2;
    localparam logic [3:0] ADDR_SW_LO   = 4'h4;
    localparam logic [3:0] ADDR_SW_HI   = 4'h6;
    localparam logic [3:0] ADDR_BTN     = 4'h8;
    localparam logic [3:0] ADDR_EVT     = 4'hA;
    localparam logic [3:0] ADDR_SNAP_LO = 4'hC;
    localparam logic [3:0] ADDR_SNAP_HI = 4'hE;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LED_W-1:0] leds_q,   leds_d;
    logic [SW_W-1:0]  sw_sync1_q, sw_sync2_q;
    logic [BTN_N-1:0] btn_sync1_q, btn_sync2_q;
    logic [CNT_W-1:0] cnt_q [BTN_N];
    logic [CNT_W-1:0] cnt_d [BTN_N];
    logic [BTN_N-1:0] stable_q, stable_d;
    logic [BTN_N-1:0] flag_q,   flag_d;
    logic [SW_W-1:0]  snap_q,   snap_d;
    logic             pending_q;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic rd_en, wr_en;
    assign rd_en = io_sel && io_read;
    assign wr_en = io_sel && io_write;

    // Zero-extended views let both halves be handled uniformly for any width;
    // bits above the real field width simply read as zero.
    logic [31:0] led_ext, sw_ext, snap_ext;
    assign led_ext  = 32'(leds_q);
    assign sw_ext   = 32'(sw_sync2_q);
    assign snap_ext = 32'(snap_q);

    // ------------------------------------------------------------------------
    // LED write path
    // ------------------------------------------------------------------------
    logic [31:0] led_wr;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        led_wr = led_ext;
        if (wr_en) begin
            case (addr)
                ADDR_LED_LO: led_wr[15:0]  = wdata;
                ADDR_LED_HI: led_wr[31:16] = wdata;
                default:     ;
            endcase
        end
        // Truncation drops bits beyond LED_W, so they are write-ignored.
        leds_d = led_wr[LED_W-1:0];
    end

    // ------------------------------------------------------------------------
    // Debounce: a button's stable level follows its synchronised input only
    // after the input has disagreed with it for DEBOUNCE_CYC consecutive edges.
    // Any agreement in between restarts the count.
    // ------------------------------------------------------------------------
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < BTN_N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (btn_sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = btn_sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Events and snapshot
    // ------------------------------------------------------------------------
    logic [BTN_N-1:0] rise;
    logic [BTN_N-1:0] clr_mask;
    logic             evt_rd_clr, evt_wr_clr;

    assign rise       = stable_d & ~stable_q;
    assign evt_rd_clr = rd_en && (addr == ADDR_EVT);
    assign evt_wr_clr = wr_en && (addr == ADDR_EVT);

    // A read clears exactly the bits it returns (the current flags). A write
    // clears the bits set in wdata. The rise term is OR-ed in last, so a new
    // event on the same edge as a clear survives.
    assign clr_mask = ({BTN_N{evt_rd_clr}} & flag_q)
                    | ({BTN_N{evt_wr_clr}} & wdata[BTN_N-1:0]);
    assign flag_d   = (flag_q & ~clr_mask) | rise;

    // The snapshot takes the synchronised switches as they were before the
    // submit edge, not the value being loaded into the sync stage on it.
    assign snap_d = rise[0] ? sw_sync2_q : snap_q;

    // ------------------------------------------------------------------------
    // Read mux: combinational so a single-cycle CPU sees data in the same cycle
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                ADDR_LED_LO:  rdata = led_ext[15:0];
                ADDR_LED_HI:  rdata = led_ext[31:16];
                ADDR_SW_LO:   rdata = sw_ext[15:0];
                ADDR_SW_HI:   rdata = sw_ext[31:16];
                ADDR_BTN:     rdata = 16'(stable_q);
                ADDR_EVT:     rdata = 16'(flag_q);
                ADDR_SNAP_LO: rdata = snap_ext[15:0];
                ADDR_SNAP_HI: rdata = snap_ext[31:16];
                default:      rdata = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and the two sync stages form a real shift chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            leds_q      <= '0;
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
            stable_q    <= '0;
            flag_q      <= '0;
            snap_q      <= '0;
            pending_q   <= 1'b0;
            // NOTE: the counter array is small flop storage, not RAM, and is
            // reset so that a reset mid-debounce discards any partial count.
            for (int i = 0; i < BTN_N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            leds_q      <= leds_d;
            sw_sync1_q  <= switches;
            sw_sync2_q  <= sw_sync1_q;
            btn_sync1_q <= buttons;
            btn_sync2_q <= btn_sync1_q;
            stable_q    <= stable_d;
            flag_q      <= flag_d;
            snap_q      <= snap_d;
            // Built from the flag next-state so it changes on the same edge
            // as the flags rather than one cycle later.
            pending_q   <= |flag_d;
            for (int i = 0; i < BTN_N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign leds          = leds_q;
    assign btn_level     = stable_q;
    assign event_pending = pending_q;

endmodule

// File: tb/tb_io_hub.sv
// -----------------------------------------------------------------------------
// tb_io_hub -- directed testbench for io_hub with a short debounce (4 cycles).
// Inputs change and outputs are sampled just after the falling clock edge, so
// "after edge N" means the falling edge that follows rising edge N.
// -----------------------------------------------------------------------------
module tb_io_hub;

    localparam int LED_W = 24;
    localparam int SW_W  = 24;
    localparam int BTN_N = 2;
    localparam int DEB   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_sel = 1'b0;
    logic              io_read = 1'b0;
    logic              io_write = 1'b0;
    logic [3:0]        addr = '0;
    logic [15:0]       wdata = '0;
    logic [15:0]       rdata;
    logic [SW_W-1:0]   switches = '0;
    logic [BTN_N-1:0]  buttons = '0;
    logic [LED_W-1:0]  leds;
    logic [BTN_N-1:0]  btn_level;
    logic              event_pending;

    int checks = 0;
    int errors = 0;

    io_hub #(
        .LED_W        (LED_W),
        .SW_W         (SW_W),
        .BTN_N        (BTN_N),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_sel        (io_sel),
        .io_read       (io_read),
        .io_write      (io_write),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .switches      (switches),
        .buttons       (buttons),
        .leds          (leds),
        .btn_level     (btn_level),
        .event_pending (event_pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One write cycle spanning exactly one rising edge.
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        io_sel   = 1'b1;
        io_write = 1'b1;
        addr     = a;
        wdata    = d;
        @(negedge clock);
        io_sel   = 1'b0;
        io_write = 1'b0;
        addr     = '0;
        wdata    = '0;
    endtask

    // Combinational peek: the read strobe is dropped before the next rising
    // edge, so no read-clear side effect happens.
    task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        io_sel  = 1'b1;
        io_read = 1'b1;
        addr    = a;
        #1;
        check(tag, 32'(rdata), 32'(exp));
        io_sel  = 1'b0;
        io_read = 1'b0;
        addr    = '0;
    endtask

    initial begin
        // ---------------- reset ----------------
        step(3);
        reset = 1'b0;
        check("rst_leds",    32'(leds),          32'h0);
        check("rst_level",   32'(btn_level),     32'h0);
        check("rst_pending", 32'(event_pending), 32'h0);
        check("idle_rdata",  32'(rdata),         32'h0);
        rd("rst_snap_lo", 4'hC, 16'h0000);

        // ---------------- LED write/readback ----------------
        wr(4'h0, 16'hA5A5);
        check("led_lo_wr", 32'(leds), 32'h0000A5A5);
        wr(4'h2, 16'h00FF);
        check("led_both_wr", 32'(leds), 32'h00FFA5A5);
        rd("led_rd0", 4'h0, 16'hA5A5);
        rd("led_rd2", 4'h2, 16'h00FF);
        wr(4'h2, 16'hFFFF);
        check("led_hi_trunc", 32'(leds), 32'h00FFA5A5);
        rd("led_rd2_trunc", 4'h2, 16'h00FF);
        wr(4'h1, 16'h0000);              // odd address: ignored
        check("odd_wr_ign", 32'(leds), 32'h00FFA5A5);
        rd("odd_rd", 4'h1, 16'h0000);
        io_read = 1'b1;                  // read strobe without select
        #1;
        check("nosel_rdata", 32'(rdata), 32'h0);
        io_read = 1'b0;

        // ---------------- switch synchroniser ----------------
        step(1);
        switches = 24'h123456;
        rd("sw_e0_lo", 4'h4, 16'h0000);
        step(1);
        rd("sw_e1_lo", 4'h4, 16'h0000);
        rd("sw_e1_hi", 4'h6, 16'h0000);
        step(1);
        rd("sw_e2_lo", 4'h4, 16'h3456);
        rd("sw_e2_hi", 4'h6, 16'h0012);

        // ---------------- debounce, button 1 held ----------------
        buttons[1] = 1'b1;
        step(DEB + 1);
        check("deb_e5_level",   32'(btn_level),     32'h0);
        check("deb_e5_pending", 32'(event_pending), 32'h0);
        step(1);
        check("deb_e6_level",   32'(btn_level),     32'h2);
        check("deb_e6_pending", 32'(event_pending), 32'h1);
        rd("deb_e6_flags", 4'hA, 16'h0002);

        // ---------------- 3-cycle glitch on button 0 ----------------
        buttons[0] = 1'b1;
        step(3);
        buttons[0] = 1'b0;
        step(8);
        check("glitch_level", 32'(btn_level), 32'h2);
        rd("glitch_flags", 4'hA, 16'h0002);

        // ---------------- submit snapshot ----------------
        switches = 24'h00ABCD;
        step(2);
        buttons[0] = 1'b1;
        step(DEB + 2);
        check("sub_level", 32'(btn_level), 32'h3);
        rd("snap_lo", 4'hC, 16'hABCD);
        rd("snap_hi", 4'hE, 16'h0000);
        switches = 24'h777777;
        step(3);
        rd("snap_hold_lo", 4'hC, 16'hABCD);
        rd("snap_hold_hi", 4'hE, 16'h0000);
        rd("sw_new_hi",    4'h6, 16'h0077);
        buttons[0] = 1'b0;               // falling edge sets nothing
        step(8);
        check("fall_level", 32'(btn_level), 32'h2);
        rd("fall_flags", 4'hA, 16'h0003);

        // ---------------- read-clear of flags ----------------
        io_sel  = 1'b1;
        io_read = 1'b1;
        addr    = 4'hA;
        #1;
        check("rdclr_data", 32'(rdata), 32'h0003);
        @(negedge clock);
        io_sel  = 1'b0;
        io_read = 1'b0;
        addr    = '0;
        check("rdclr_pending", 32'(event_pending), 32'h0);
        rd("rdclr_flags", 4'hA, 16'h0000);

        // ---------------- W1C on the same edge as a new rise ----------------
        buttons[1] = 1'b0;
        step(8);
        check("b1_released", 32'(btn_level), 32'h0);
        buttons[1] = 1'b1;
        step(DEB + 1);
        check("w1c_pre_level", 32'(btn_level), 32'h0);
        wr(4'hA, 16'h0002);              // spans edge 6, where the rise lands
        check("w1c_set_wins_pend", 32'(event_pending), 32'h1);
        rd("w1c_set_wins", 4'hA, 16'h0002);
        wr(4'hA, 16'h0002);
        check("w1c_clr_pend", 32'(event_pending), 32'h0);
        rd("w1c_clr", 4'hA, 16'h0000);

        // ---------------- reset mid-debounce ----------------
        buttons[1] = 1'b0;
        step(8);
        buttons[1] = 1'b1;
        step(4);                         // counter is now at 2
        reset = 1'b1;
        step(1);
        check("mid_rst_leds",    32'(leds),          32'h0);
        check("mid_rst_level",   32'(btn_level),     32'h0);
        check("mid_rst_pending", 32'(event_pending), 32'h0);
        rd("mid_rst_sw",   4'h4, 16'h0000);
        rd("mid_rst_snap", 4'hC, 16'h0000);
        reset = 1'b0;
        step(DEB + 1);
        check("post_rst_e5", 32'(btn_level), 32'h0);
        step(1);
        check("post_rst_e6",     32'(btn_level),     32'h2);
        check("post_rst_pend",   32'(event_pending), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_hub.md
Name: io_hub

Overview:
- Parametrised memory-mapped IO subsystem; replaces the separate LED and switch blocks in the CPU top level.
- The CPU reaches it through the same MemOrIO strobes, plus a single select line.
- Adds 2-flop synchronisation of switches and buttons, per-button debounce with counters, sticky press-event flags, an interrupt-style pending flag, and a switch snapshot captured on button-0 press ("submit").
- Read data is combinational from registered state, so a single-cycle CPU reads it in the same cycle.

Parameters:
- LED_W, 24, number of LED outputs; range 1..32.
- SW_W, 24, number of switch inputs; range 1..32.
- BTN_N, 2, number of push buttons; range 1..16.
- DEBOUNCE_CYC, 20, consecutive stable cycles needed to accept a button change; must be ≥2.

Ports:
- clock  in  1  system clock (CPU clock)
- reset  in  1  synchronous, active-high reset
- io_sel  in  1  address decoded to the IO hub region
- io_read  in  1  CPU IO read strobe
- io_write  in  1  CPU IO write strobe
- addr  in  4  low byte-address bits; halfword registers
- wdata  in  16  write data (rt low half)
- rdata  out  16  read data, combinational
- switches  in  SW_W  raw board switches
- buttons  in  BTN_N  raw board buttons
- leds  out  LED_W  LED drive, registered
- btn_level  out  BTN_N  debounced button levels
- event_pending  out  1  OR of all event flags, registered

Behaviour:
- Reset is synchronous, active-high, and has priority over all other activity. Registers cleared by reset:
  - leds
  - both sync stages
  - debounce counters and stable levels
  - event flags
  - snapshot
  - event_pending
- Reset mid-debounce discards the partial count.
- Register map (addr):
  - 0x0 LED[15:0] (R/W)
  - 0x2 LED[LED_W-1:16] (R/W)
  - 0x4 SW_sync[15:0] (R)
  - 0x6 SW_sync[SW_W-1:16] (R)
  - 0x8 btn_level (R)
  - 0xA event flags (R; read-clear; W1C)
  - 0xC snapshot[15:0] (R)
  - 0xE snapshot[SW_W-1:16] (R)
- Register width rules:
  - Fields narrower than 16 bits read zero-extended.
  - Bits beyond LED_W are write-ignored.
  - If LED_W≤16 or SW_W≤16, the high halves read 0.
- Unmapped or odd addresses: read 0, writes ignored.
- rdata is 0 when io_sel and io_read are not both high.
- Writes take effect at the clock edge when io_sel && io_write. Writes to read-only registers are ignored.
- Synchroniser: switches and buttons each pass through 2 flops. SW_sync is the second stage.
- Debounce, per button:
  - Each button has a counter of width clog2(DEBOUNCE_CYC) and a stable level.
  - On each edge, if sync2 == stable, the counter clears.
  - Otherwise, if counter == DEBOUNCE_CYC-1, then stable <= sync2 and counter <= 0; else counter increments.
  - Consequence: a raw change settled before edge 1 updates stable at edge DEBOUNCE_CYC+2.
  - A glitch shorter than DEBOUNCE_CYC cycles at sync2 never changes stable.
  - btn_level = stable.
- Events:
  - On the edge where stable[i] goes 0→1, flag[i] sets. Falling edges set nothing.
  - Flags are sticky.
  - Clear by a read of 0xA: at that edge, bits returned in rdata are cleared.
  - Clear by a write of 0xA: W1C using wdata[BTN_N-1:0].
  - If a set and a clear hit the same bit on the same edge, set wins.
- Snapshot: on the edge where stable[0] rises, snapshot <= SW_sync (the value before that edge).
- event_pending is registered: the OR of the flag next-state, so it tracks the flags with no extra cycle.

Test Plan:
- LED write and readback:
  - Stimulus: reset, then write 0x0=0xA5A5 and 0x2=0x00FF.
  - Required: leds=0x00FFA5A5 one edge later; reads return 0xA5A5 and 0x00FF.
  - Stimulus: write 0x2=0xFFFF.
  - Required: leds[23:16]=0xFF, and a read of 0x2 returns 0x00FF.
- Switch path:
  - Stimulus: switches=0x123456.
  - Required: reads of 0x4 and 0x6 return 0x3456 and 0x0012 from the 2nd edge on; both return the old value before that.
- Debounce:
  - Stimulus: DEBOUNCE_CYC=4; buttons[1] raised and held.
  - Required: btn_level[1]=1 exactly after edge 6; flag bit1 set; event_pending=1 at the same edge.
  - Stimulus: a 3-cycle pulse.
  - Required: no level change and no flag.
- Submit snapshot:
  - Stimulus: switches=0x00ABCD, then press button 0.
  - Required: snapshot reads 0xABCD and 0x0000; changing switches afterwards leaves the snapshot unchanged until the next press.
- Event clear:
  - Stimulus: read 0xA while flags=0b11.
  - Required: returns 0x0003; flags=0 and event_pending=0 after that edge.
  - Stimulus: W1C 0x0002 on the same edge as a new button-1 rise.
  - Required: bit1 stays 1.
- Reset mid-operation:
  - Stimulus: assert reset while a debounce count is at 2 and the LEDs are lit.
  - Required: all outputs are 0 at the next edge; a held button needs the full DEBOUNCE_CYC+2 edges again after reset is released.
